// File: rtl/wb_update_ctrl.sv
// Mini-batch scheduler for the delta weight/bias accumulator bank.
// Optional macro WBC_ABORT_EN adds an i_abort input that cancels a run.
module wb_update_ctrl #(
  parameter int unsigned BATCH_SIZE = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned ACC_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_n_batch,
  input  logic             i_smp_valid,
  output logic             o_smp_ready,
  output logic             o_acc_en,
  output logic             o_acc_rst,
  output logic             o_upd_valid,
  input  logic             i_upd_ready,
  output logic [CNT_W-1:0] o_smp_cnt,
  output logic [CNT_W-1:0] o_batch_cnt,
  output logic             o_busy,
  output logic             o_done
`ifdef WBC_ABORT_EN
  ,
  input  logic             i_abort
`endif
);

  localparam int unsigned DW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
  localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(BATCH_SIZE - 1);
  localparam logic [DW-1:0]    LAT_LAST = DW'(ACC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_DRAIN,
    S_UPD,
    S_CLR,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] n_batch_q;
  logic [CNT_W-1:0] smp_cnt_q;
  logic [CNT_W-1:0] batch_cnt_q;
  logic [DW-1:0]    drain_q;
  logic             smp_ready_q;
  logic             upd_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             abort_req;
  logic             hs;

`ifdef WBC_ABORT_EN
  logic abort_q;
  assign abort_req = i_abort &&
                     (state_q == S_ACC || state_q == S_DRAIN || state_q == S_UPD);
`else
  assign abort_req = 1'b0;
`endif

  // smp_ready_q is only ever set while in ACC; rst gating keeps en low in reset
  assign hs        = i_smp_valid & smp_ready_q & rst & ~abort_req;
  assign o_acc_en  = hs;
  assign o_acc_rst = rst & (state_q != S_CLR);

  assign o_smp_ready = smp_ready_q;
  assign o_upd_valid = upd_valid_q;
  assign o_smp_cnt   = smp_cnt_q;
  assign o_batch_cnt = batch_cnt_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      n_batch_q   <= '0;
      smp_cnt_q   <= '0;
      batch_cnt_q <= '0;
      drain_q     <= '0;
      smp_ready_q <= 1'b0;
      upd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef WBC_ABORT_EN
      abort_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (abort_req) begin
        state_q     <= S_CLR;
        smp_ready_q <= 1'b0;
        upd_valid_q <= 1'b0;
`ifdef WBC_ABORT_EN
        abort_q     <= 1'b1;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_start) begin
              n_batch_q   <= i_n_batch;
              smp_cnt_q   <= '0;
              batch_cnt_q <= '0;
              busy_q      <= 1'b1;
              if (i_n_batch == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q     <= S_ACC;
                smp_ready_q <= 1'b1;
              end
            end
          end
          S_ACC: begin
            if (hs) begin
              if (smp_cnt_q == SMP_LAST) begin
                smp_cnt_q   <= '0;
                smp_ready_q <= 1'b0;
                drain_q     <= '0;
                state_q     <= S_DRAIN;
              end else begin
                smp_cnt_q <= smp_cnt_q + CNT_W'(1);
              end
            end
          end
          S_DRAIN: begin
            if (drain_q == LAT_LAST) begin
              upd_valid_q <= 1'b1;
              state_q     <= S_UPD;
            end else begin
              drain_q <= drain_q + DW'(1);
            end
          end
          S_UPD: begin
            // count advances on the way into CLR so CLR can compare directly
            if (i_upd_ready) begin
              upd_valid_q <= 1'b0;
              batch_cnt_q <= batch_cnt_q + CNT_W'(1);
              state_q     <= S_CLR;
            end
          end
          S_CLR: begin
`ifdef WBC_ABORT_EN
            if (abort_q) begin
              abort_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else
`endif
            if (batch_cnt_q == n_batch_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              smp_ready_q <= 1'b1;
              state_q     <= S_ACC;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q      <= 1'b0;
            smp_ready_q <= 1'b0;
            upd_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_update_ctrl.sv
// Directed self-checking bench for wb_update_ctrl (BATCH_SIZE=4, ACC_LAT=2).
module tb_wb_update_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [7:0] i_n_batch;
  logic       i_smp_valid;
  logic       o_smp_ready;
  logic       o_acc_en;
  logic       o_acc_rst;
  logic       o_upd_valid;
  logic       i_upd_ready;
  logic [7:0] o_smp_cnt;
  logic [7:0] o_batch_cnt;
  logic       o_busy;
  logic       o_done;
`ifdef WBC_ABORT_EN
  logic       i_abort;
`endif

  int checks = 0;
  int errors = 0;

  wb_update_ctrl #(
    .BATCH_SIZE(4),
    .CNT_W     (8),
    .ACC_LAT   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_n_batch  (i_n_batch),
    .i_smp_valid(i_smp_valid),
    .o_smp_ready(o_smp_ready),
    .o_acc_en   (o_acc_en),
    .o_acc_rst  (o_acc_rst),
    .o_upd_valid(o_upd_valid),
    .i_upd_ready(i_upd_ready),
    .o_smp_cnt  (o_smp_cnt),
    .o_batch_cnt(o_batch_cnt),
    .o_busy     (o_busy),
    .o_done     (o_done)
`ifdef WBC_ABORT_EN
    ,
    .i_abort    (i_abort)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_upd(input int budget);
    int n;
    n = 0;
    while (o_upd_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("upd_valid_timeout", {31'd0, o_upd_valid}, 1);
  endtask

  initial begin
    int pulses, offers, dones, n;
    logic bad_valid, bad_ready, bad_en;

    rst = 1'b0; i_start = 1'b0; i_n_batch = '0; i_smp_valid = 1'b1; i_upd_ready = 1'b0;
`ifdef WBC_ABORT_EN
    i_abort = 1'b0;
`endif
    step(); step();
    chk("rst_ready", {31'd0, o_smp_ready}, 0);
    chk("rst_acc_en", {31'd0, o_acc_en}, 0);
    chk("rst_acc_rst", {31'd0, o_acc_rst}, 0);
    chk("rst_upd_valid", {31'd0, o_upd_valid}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_done", {31'd0, o_done}, 0);
    chk("rst_smp_cnt", {24'd0, o_smp_cnt}, 0);
    chk("rst_batch_cnt", {24'd0, o_batch_cnt}, 0);
    rst = 1'b1;
    step();
    chk("idle_acc_rst", {31'd0, o_acc_rst}, 1);
    chk("idle_valid_no_en", {31'd0, o_acc_en}, 0);

    // Test 1: one batch, valid held high
    i_n_batch = 8'd1; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_ready", {31'd0, o_smp_ready}, 1);
      chk("t1_acc_en", {31'd0, o_acc_en}, 1);
      chk("t1_smp_cnt", {24'd0, o_smp_cnt}, i);
      step();
    end
    chk("t1_drain0_en", {31'd0, o_acc_en}, 0);
    chk("t1_drain0_ready", {31'd0, o_smp_ready}, 0);
    chk("t1_drain0_cnt", {24'd0, o_smp_cnt}, 0);
    chk("t1_drain0_upd", {31'd0, o_upd_valid}, 0);
    step();
    chk("t1_drain1_upd", {31'd0, o_upd_valid}, 0);
    chk("t1_drain1_en", {31'd0, o_acc_en}, 0);
    step();
    chk("t1_upd_valid", {31'd0, o_upd_valid}, 1);
    i_upd_ready = 1'b1;
    step();
    i_upd_ready = 1'b0;
    chk("t1_clr_upd", {31'd0, o_upd_valid}, 0);
    chk("t1_clr_acc_rst", {31'd0, o_acc_rst}, 0);
    chk("t1_clr_done", {31'd0, o_done}, 0);
    step();
    chk("t1_done", {31'd0, o_done}, 1);
    chk("t1_done_acc_rst", {31'd0, o_acc_rst}, 1);
    chk("t1_batch_cnt", {24'd0, o_batch_cnt}, 1);
    step();
    chk("t1_done_pulse_end", {31'd0, o_done}, 0);
    chk("t1_idle_busy", {31'd0, o_busy}, 0);
    chk("t1_batch_hold", {24'd0, o_batch_cnt}, 1);

    // Test 2: three batches, valid toggling
    i_n_batch = 8'd3; i_start = 1'b1;
    step();
    i_start = 1'b0; i_upd_ready = 1'b1;
    pulses = 0; offers = 0; dones = 0;
    for (int c = 0; c < 150; c++) begin
      i_smp_valid = (c % 2 == 0);
      #1;
      if (o_acc_en) pulses++;
      if (o_upd_valid) offers++;
      if (o_done) dones++;
      step();
    end
    chk("t2_acc_en_pulses", pulses, 12);
    chk("t2_upd_offers", offers, 3);
    chk("t2_done_pulses", dones, 1);
    chk("t2_batch_cnt", {24'd0, o_batch_cnt}, 3);
    chk("t2_busy", {31'd0, o_busy}, 0);

    // Test 3: updater stalls for 10 cycles, start ignored while busy
    i_upd_ready = 1'b0; i_smp_valid = 1'b1; i_n_batch = 8'd1; i_start = 1'b1;
    step();
    i_start = 1'b1; i_n_batch = 8'd7;
    wait_upd(20);
    bad_valid = 1'b0; bad_ready = 1'b0; bad_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (o_upd_valid !== 1'b1) bad_valid = 1'b1;
      if (o_smp_ready !== 1'b0) bad_ready = 1'b1;
      if (o_acc_en !== 1'b0) bad_en = 1'b1;
      step();
    end
    chk("t3_hold_valid_err", {31'd0, bad_valid}, 0);
    chk("t3_hold_ready_err", {31'd0, bad_ready}, 0);
    chk("t3_hold_en_err", {31'd0, bad_en}, 0);
    i_start = 1'b0; i_upd_ready = 1'b1;
    step();
    i_upd_ready = 1'b0;
    step();
    chk("t3_done", {31'd0, o_done}, 1);
    chk("t3_batch_cnt", {24'd0, o_batch_cnt}, 1);
    step();

    // Test 4: zero batches
    i_n_batch = 8'd0; i_start = 1'b1; i_smp_valid = 1'b1;
    step();
    i_start = 1'b0;
    chk("t4_done", {31'd0, o_done}, 1);
    chk("t4_no_en", {31'd0, o_acc_en}, 0);
    chk("t4_busy", {31'd0, o_busy}, 1);
    chk("t4_batch_cnt", {24'd0, o_batch_cnt}, 0);
    step();
    chk("t4_done_end", {31'd0, o_done}, 0);
    chk("t4_idle", {31'd0, o_busy}, 0);

    // Test 5: reset mid-batch
    i_n_batch = 8'd2; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step(); step();
    chk("t5_smp_cnt_pre", {24'd0, o_smp_cnt}, 2);
    rst = 1'b0;
    #1;
    chk("t5_acc_rst_low", {31'd0, o_acc_rst}, 0);
    step();
    chk("t5_smp_cnt", {24'd0, o_smp_cnt}, 0);
    chk("t5_busy", {31'd0, o_busy}, 0);
    chk("t5_ready", {31'd0, o_smp_ready}, 0);
    chk("t5_acc_rst", {31'd0, o_acc_rst}, 0);
    rst = 1'b1;
    step();

    // Maximum batch count: no wrap before termination
    i_n_batch = 8'd255; i_start = 1'b1; i_smp_valid = 1'b1; i_upd_ready = 1'b1;
    step();
    i_start = 1'b0;
    n = 0;
    while (o_done !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    chk("max_done", {31'd0, o_done}, 1);
    chk("max_batch_cnt", {24'd0, o_batch_cnt}, 255);
    step();
    chk("max_idle", {31'd0, o_busy}, 0);

`ifdef WBC_ABORT_EN
    // Test 6: abort during update offer
    i_upd_ready = 1'b0; i_n_batch = 8'd2; i_start = 1'b1;
    step();
    i_start = 1'b0;
    wait_upd(20);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("t6_upd_drop", {31'd0, o_upd_valid}, 0);
    chk("t6_clr", {31'd0, o_acc_rst}, 0);
    chk("t6_batch_cnt", {24'd0, o_batch_cnt}, 0);
    step();
    chk("t6_idle", {31'd0, o_busy}, 0);
    chk("t6_no_done", {31'd0, o_done}, 0);
    chk("t6_acc_rst", {31'd0, o_acc_rst}, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
